regfile_wb_scheduler: RTL and testbench
=======================================

# regfile_wb_scheduler

Write-back scheduler and hazard scoreboard for the core's register file. Shares the register file's single write port between two write-back sources (A: ALU, B: load unit) with round-robin arbitration. Tracks destination registers of issued-but-not-written instructions and stalls issue on RAW/WAW hazards. Sits between the issue stage, the two execution units and the register file's write/read ports.

## Interface
- XLEN, 32, data width (matches register file width)
- REG_NUMBER, 32, number of architectural registers
- AW, $clog2(REG_NUMBER), register address width (derived, not overridden)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- iss_valid  in  1  issue stage presents an instruction
- iss_rd / iss_rs1 / iss_rs2  in  AW  destination / source register addresses
- iss_stall  out  1  instruction must not issue this cycle
- a_valid, b_valid  in  1  source A/B has a write-back pending
- a_ready, b_ready  out  1  source A/B write-back accepted this cycle
- a_rd, b_rd  in  AW  write-back destination
- a_data, b_data  in  XLEN  write-back data
- rf_write  out  1  register file write enable
- rf_sel_write_reg  out  AW  register file write address
- rf_data_in  out  XLEN  register file write data
- rf_data_out1 / rf_data_out2  in  XLEN  register file read data for iss_rs1 / iss_rs2
- rs1_data / rs2_data  out  XLEN  operand data to execution units
- err_unexp  out  1  sticky: write-back accepted to a register not marked pending

## Operation
- Arbitration (combinational grant, state in rr_last: 0 = A granted last, 1 = B):
  - only one valid -> that source granted; both valid -> source not equal to rr_last granted; none -> no grant.
  - a_ready/b_ready = grant; handshake completes on valid & ready at the rising edge; rr_last updates to granted source.
- Write port: on grant, rf_write = 1 unless granted rd == 0; rf_sel_write_reg/rf_data_in = granted rd/data (forced to 0 when no grant). x0 write-backs are accepted and dropped.
- Scoreboard pend[REG_NUMBER-1:1]; pend[0] is constant 0.
  - issue fires when iss_valid & ~iss_stall & iss_rd != 0 -> pend[iss_rd] set at edge.
  - accepted write-back with rd != 0 -> pend[rd] cleared at edge.
  - same rd set and cleared in same cycle -> set wins (new producer).
  - accepted write-back with rd != 0 and pend[rd] == 0 -> err_unexp set; stays 1 until reset.
- iss_stall = iss_valid & (hz(iss_rs1) | hz(iss_rs2) | hz(iss_rd)); hz(r) = pend[r], r = 0 never hazards.
- rs1_data/rs2_data = rf_data_out1/rf_data_out2 (see Configuration).

## Timing
- Reset (while reset = 1 and first cycle after): pend all 0, rr_last = 1 (A wins first tie), err_unexp = 0; a_ready = b_ready = 0, rf_write = 0, rf_sel_write_reg = 0, rf_data_in = 0, iss_stall = 0 while reset is high.
- Write-back latency: zero cycles; register file updated at the same edge the handshake completes.
- Scoreboard update visible to iss_stall the cycle after the issuing/write-back edge.
- At most one write per cycle; losing source holds valid/rd/data stable until granted; max wait one cycle under continuous contention.
- Reset asserted mid-operation: all pending state discarded, no write in that cycle.

## Configuration
- REGFILE_WB_BYPASS_EN defined: hz(r) also requires r not being written this cycle (pend[r] & ~(rf_write & rf_sel_write_reg == r)); rsN_data = rf_data_in when rf_write & rf_sel_write_reg == iss_rsN & iss_rsN != 0, else rf_data_outN.
- Not defined: hz(r) = pend[r] only; rsN_data = rf_data_outN unconditionally; one extra stall cycle on every RAW resolving at write-back.

## Test plan
- Reset then issue rd=5 (rs1=rs2=0) -> iss_stall 0, next cycle issue rs1=5 -> iss_stall 1; A writes rd=5 data 0xDEADBEEF -> rf_write 1, addr 5; without bypass stall drops next cycle, with bypass stall 0 same cycle and rs1_data = 0xDEADBEEF.
- A and B valid continuously for 4 cycles (rd 1..4 pending) -> grants A,B,A,B; exactly one rf_write per cycle.
- B write-back rd=0 data 0x1234 -> b_ready 1, rf_write 0, err_unexp stays 0.
- A write-back rd=7 with pend[7]=0 -> accepted, rf_write 1, err_unexp 1 and held until reset.
- Issue rd=3 same cycle as write-back rd=3 clears older producer -> pend[3] remains 1; later issue with rs2=3 stalls.
- Reset asserted while pend[9]=1 and A valid -> a_ready 0, rf_write 0; after release issue rs1=9 -> iss_stall 0.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// Write-back arbiter and RAW/WAW hazard scoreboard for the register file's single write port.
// Optional feature: define REGFILE_WB_BYPASS_EN to forward the same-cycle write-back into hazard checks and operands.
module regfile_wb_scheduler #(
    parameter  int XLEN       = 32,
    parameter  int REG_NUMBER = 32,
    localparam int AW         = $clog2(REG_NUMBER)
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   iss_rs1,
    input  logic [AW-1:0]   iss_rs2,
    output logic            iss_stall,

    input  logic            a_valid,
    output logic            a_ready,
    input  logic [AW-1:0]   a_rd,
    input  logic [XLEN-1:0] a_data,

    input  logic            b_valid,
    output logic            b_ready,
    input  logic [AW-1:0]   b_rd,
    input  logic [XLEN-1:0] b_data,

    output logic            rf_write,
    output logic [AW-1:0]   rf_sel_write_reg,
    output logic [XLEN-1:0] rf_data_in,
    input  logic [XLEN-1:0] rf_data_out1,
    input  logic [XLEN-1:0] rf_data_out2,

    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            err_unexp
);

    // rr_last: 0 = A granted last, 1 = B granted last
    logic                  rr_last;
    logic [REG_NUMBER-1:0] pend;
    logic [REG_NUMBER-1:0] pend_next;
    logic [REG_NUMBER-1:0] written_mask;
    logic [REG_NUMBER-1:0] hz_vec;
    logic                  grant_a;
    logic                  grant_b;
    logic                  wb_fire;
    logic                  issue_fire;

    // Round-robin grant; both grants are suppressed while reset is high
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset) begin
            grant_a = a_valid & (~b_valid | rr_last);
            grant_b = b_valid & (~a_valid | ~rr_last);
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign wb_fire = grant_a | grant_b;

    always_comb begin
        rf_sel_write_reg = '0;
        rf_data_in       = '0;
        if (grant_a) begin
            rf_sel_write_reg = a_rd;
            rf_data_in       = a_data;
        end else if (grant_b) begin
            rf_sel_write_reg = b_rd;
            rf_data_in       = b_data;
        end
    end

    // x0 write-backs complete the handshake but never reach the register file
    assign rf_write = wb_fire & (rf_sel_write_reg != '0);

`ifdef REGFILE_WB_BYPASS_EN
    always_comb begin
        written_mask = '0;
        if (rf_write) begin
            written_mask[rf_sel_write_reg] = 1'b1;
        end
    end

    always_comb begin
        rs1_data = rf_data_out1;
        rs2_data = rf_data_out2;
        if (rf_write && (rf_sel_write_reg == iss_rs1) && (iss_rs1 != '0)) begin
            rs1_data = rf_data_in;
        end
        if (rf_write && (rf_sel_write_reg == iss_rs2) && (iss_rs2 != '0)) begin
            rs2_data = rf_data_in;
        end
    end
`else
    assign written_mask = '0;
    assign rs1_data     = rf_data_out1;
    assign rs2_data     = rf_data_out2;
`endif

    assign hz_vec = pend & ~written_mask;

    always_comb begin
        iss_stall = 1'b0;
        if (!reset && iss_valid) begin
            iss_stall = hz_vec[iss_rs1] | hz_vec[iss_rs2] | hz_vec[iss_rd];
        end
    end

    assign issue_fire = iss_valid & ~iss_stall & (iss_rd != '0) & ~reset;

    // Clear before set so a new producer issued on the write-back edge keeps the register pending
    always_comb begin
        pend_next = pend;
        if (rf_write) begin
            pend_next[rf_sel_write_reg] = 1'b0;
        end
        if (issue_fire) begin
            pend_next[iss_rd] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend      <= '0;
            rr_last   <= 1'b1;
            err_unexp <= 1'b0;
        end else begin
            pend <= pend_next;
            if (wb_fire) begin
                rr_last <= grant_b;
            end
            if (rf_write && !pend[rf_sel_write_reg]) begin
                err_unexp <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed self-checking bench for regfile_wb_scheduler; models the register file behind the write port.
module tb_regfile_wb_scheduler;

    localparam int XLEN = 32;
    localparam int AW   = 5;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd, iss_rs1, iss_rs2;
    logic            iss_stall;
    logic            a_valid, a_ready, b_valid, b_ready;
    logic [AW-1:0]   a_rd, b_rd;
    logic [XLEN-1:0] a_data, b_data;
    logic            rf_write;
    logic [AW-1:0]   rf_sel_write_reg;
    logic [XLEN-1:0] rf_data_in, rf_data_out1, rf_data_out2;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            err_unexp;

    logic [XLEN-1:0] rf_mem [32];
    int passed = 0;
    int total  = 0;

    regfile_wb_scheduler dut (
        .clk(clk), .reset(reset),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_stall(iss_stall),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .rf_write(rf_write), .rf_sel_write_reg(rf_sel_write_reg), .rf_data_in(rf_data_in),
        .rf_data_out1(rf_data_out1), .rf_data_out2(rf_data_out2),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .err_unexp(err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
        end else if (rf_write) begin
            rf_mem[rf_sel_write_reg] <= rf_data_in;
        end
    end
    assign rf_data_out1 = rf_mem[iss_rs1];
    assign rf_data_out2 = rf_mem[iss_rs2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
    endtask

    task automatic apply_reset();
        reset = 1;
        idle_inputs();
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        iss_valid = 1; iss_rd = 5'd5; iss_rs1 = 5'd3; iss_rs2 = 5'd0;
        a_valid = 1; a_rd = 5'd2; a_data = 32'h1111_2222;
        b_valid = 1; b_rd = 5'd4; b_data = 32'h3333_4444;
        tick();
        tick();
        total++; if (a_ready !== 1'b0) $display("FAIL reset_a_ready got %0b want 0", a_ready); else passed++;
        total++; if (b_ready !== 1'b0) $display("FAIL reset_b_ready got %0b want 0", b_ready); else passed++;
        total++; if (rf_write !== 1'b0) $display("FAIL reset_rf_write got %0b want 0", rf_write); else passed++;
        total++; if (rf_sel_write_reg !== 5'd0) $display("FAIL reset_sel got %0d want 0", rf_sel_write_reg); else passed++;
        total++; if (rf_data_in !== 32'h0) $display("FAIL reset_data_in got %h want 0", rf_data_in); else passed++;
        total++; if (iss_stall !== 1'b0) $display("FAIL reset_stall got %0b want 0", iss_stall); else passed++;
        total++; if (err_unexp !== 1'b0) $display("FAIL reset_err got %0b want 0", err_unexp); else passed++;
        reset = 0;
        idle_inputs();
        tick();
    endtask

    task automatic test_raw();
        iss_valid = 1; iss_rd = 5'd5; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
        #1;
        total++; if (iss_stall !== 1'b0) $display("FAIL raw_issue_rd5 stall got %0b want 0", iss_stall); else passed++;
        tick();
        iss_rd = 5'd0; iss_rs1 = 5'd5;
        #1;
        total++; if (iss_stall !== 1'b1) $display("FAIL raw_rs1_pending stall got %0b want 1", iss_stall); else passed++;
        tick();
        a_valid = 1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
        #1;
        total++; if (a_ready !== 1'b1) $display("FAIL raw_wb_a_ready got %0b want 1", a_ready); else passed++;
        total++; if (rf_write !== 1'b1) $display("FAIL raw_wb_rf_write got %0b want 1", rf_write); else passed++;
        total++; if (rf_sel_write_reg !== 5'd5) $display("FAIL raw_wb_sel got %0d want 5", rf_sel_write_reg); else passed++;
        total++; if (rf_data_in !== 32'hDEADBEEF) $display("FAIL raw_wb_data got %h want deadbeef", rf_data_in); else passed++;
        total++; if (iss_stall !== !BYPASS) $display("FAIL raw_wb_stall got %0b want %0b", iss_stall, !BYPASS); else passed++;
        total++; if (rs1_data !== (BYPASS ? 32'hDEADBEEF : 32'h0))
            $display("FAIL raw_wb_rs1_data got %h want %h", rs1_data, (BYPASS ? 32'hDEADBEEF : 32'h0)); else passed++;
        tick();
        a_valid = 0;
        #1;
        total++; if (iss_stall !== 1'b0) $display("FAIL raw_after_wb stall got %0b want 0", iss_stall); else passed++;
        total++; if (rs1_data !== 32'hDEADBEEF) $display("FAIL raw_after_wb rs1_data got %h want deadbeef", rs1_data); else passed++;
        tick();
        iss_valid = 0;
        total++; if (err_unexp !== 1'b0) $display("FAIL raw_err got %0b want 0", err_unexp); else passed++;
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int k = 1; k <= 4; k++) begin
            iss_valid = 1; iss_rd = AW'(k); iss_rs1 = 0; iss_rs2 = 0;
            #1;
            total++; if (iss_stall !== 1'b0) $display("FAIL rr_issue_%0d stall got %0b want 0", k, iss_stall); else passed++;
            tick();
        end
        iss_valid = 0; iss_rd = 0;
        a_valid = 1; a_rd = 5'd1; a_data = 32'hA000_0001;
        b_valid = 1; b_rd = 5'd2; b_data = 32'hB000_0002;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++; if (a_ready !== (c % 2 == 0)) $display("FAIL rr_cycle%0d a_ready got %0b want %0b", c, a_ready, (c % 2 == 0)); else passed++;
            total++; if (b_ready !== (c % 2 == 1)) $display("FAIL rr_cycle%0d b_ready got %0b want %0b", c, b_ready, (c % 2 == 1)); else passed++;
            total++; if (rf_write !== 1'b1) $display("FAIL rr_cycle%0d rf_write got %0b want 1", c, rf_write); else passed++;
            total++; if (rf_sel_write_reg !== AW'(c + 1)) $display("FAIL rr_cycle%0d sel got %0d want %0d", c, rf_sel_write_reg, c + 1); else passed++;
            total++; if (rf_data_in !== (((c % 2 == 0) ? 32'hA000_0000 : 32'hB000_0000) | 32'(c + 1)))
                $display("FAIL rr_cycle%0d data got %h want %h", c, rf_data_in, (((c % 2 == 0) ? 32'hA000_0000 : 32'hB000_0000) | 32'(c + 1))); else passed++;
            tick();
            if (c == 0) begin a_rd = 5'd3; a_data = 32'hA000_0003; end
            if (c == 1) begin b_rd = 5'd4; b_data = 32'hB000_0004; end
            if (c == 2) begin a_rd = 5'd6; a_data = 32'hA000_0006; end
        end
        a_valid = 0; b_valid = 0;
        iss_valid = 1; iss_rd = 5'd2; iss_rs1 = 5'd1; iss_rs2 = 5'd4;
        #1;
        total++; if (iss_stall !== 1'b0) $display("FAIL rr_pend_cleared stall got %0b want 0", iss_stall); else passed++;
        total++; if (err_unexp !== 1'b0) $display("FAIL rr_err got %0b want 0", err_unexp); else passed++;
        idle_inputs();
        tick();
    endtask

    task automatic test_x0_writeback();
        b_valid = 1; b_rd = 5'd0; b_data = 32'h0000_1234;
        #1;
        total++; if (b_ready !== 1'b1) $display("FAIL x0_b_ready got %0b want 1", b_ready); else passed++;
        total++; if (rf_write !== 1'b0) $display("FAIL x0_rf_write got %0b want 0", rf_write); else passed++;
        tick();
        b_valid = 0;
        #1;
        total++; if (err_unexp !== 1'b0) $display("FAIL x0_err got %0b want 0", err_unexp); else passed++;
        tick();
    endtask

    task automatic test_waw_same_cycle();
        iss_valid = 1; iss_rd = 5'd3; iss_rs1 = 0; iss_rs2 = 0;
        #1;
        total++; if (iss_stall !== 1'b0) $display("FAIL waw_first_issue stall got %0b want 0", iss_stall); else passed++;
        tick();
        a_valid = 1; a_rd = 5'd3; a_data = 32'hA000_0003;
        #1;
        total++; if (a_ready !== 1'b1) $display("FAIL waw_a_ready got %0b want 1", a_ready); else passed++;
        total++; if (rf_write !== 1'b1) $display("FAIL waw_rf_write got %0b want 1", rf_write); else passed++;
        total++; if (iss_stall !== !BYPASS) $display("FAIL waw_same_cycle stall got %0b want %0b", iss_stall, !BYPASS); else passed++;
        tick();
        a_valid = 0;
        iss_valid = !BYPASS;
        #1;
        total++; if (iss_stall !== 1'b0) $display("FAIL waw_retry stall got %0b want 0", iss_stall); else passed++;
        tick();
        iss_valid = 1; iss_rd = 5'd0; iss_rs2 = 5'd3;
        #1;
        total++; if (iss_stall !== 1'b1) $display("FAIL waw_rs2_still_pending stall got %0b want 1", iss_stall); else passed++;
        total++; if (err_unexp !== 1'b0) $display("FAIL waw_err got %0b want 0", err_unexp); else passed++;
        idle_inputs();
        tick();
    endtask

    task automatic test_unexpected();
        a_valid = 1; a_rd = 5'd7; a_data = 32'h7777_7777;
        #1;
        total++; if (a_ready !== 1'b1) $display("FAIL unexp_a_ready got %0b want 1", a_ready); else passed++;
        total++; if (rf_write !== 1'b1) $display("FAIL unexp_rf_write got %0b want 1", rf_write); else passed++;
        total++; if (err_unexp !== 1'b0) $display("FAIL unexp_err_before got %0b want 0", err_unexp); else passed++;
        tick();
        a_valid = 0;
        #1;
        total++; if (err_unexp !== 1'b1) $display("FAIL unexp_err_set got %0b want 1", err_unexp); else passed++;
        tick();
        tick();
        total++; if (err_unexp !== 1'b1) $display("FAIL unexp_err_sticky got %0b want 1", err_unexp); else passed++;
    endtask

    task automatic test_reset_midop();
        iss_valid = 1; iss_rd = 5'd9; iss_rs1 = 0; iss_rs2 = 0;
        #1;
        total++; if (iss_stall !== 1'b0) $display("FAIL midrst_issue_rd9 stall got %0b want 0", iss_stall); else passed++;
        tick();
        iss_valid = 0;
        reset = 1;
        a_valid = 1; a_rd = 5'd9; a_data = 32'h9999_9999;
        #1;
        total++; if (a_ready !== 1'b0) $display("FAIL midrst_a_ready got %0b want 0", a_ready); else passed++;
        total++; if (rf_write !== 1'b0) $display("FAIL midrst_rf_write got %0b want 0", rf_write); else passed++;
        tick();
        reset = 0;
        a_valid = 0;
        #1;
        total++; if (err_unexp !== 1'b0) $display("FAIL midrst_err_cleared got %0b want 0", err_unexp); else passed++;
        iss_valid = 1; iss_rd = 5'd0; iss_rs1 = 5'd9;
        #1;
        total++; if (iss_stall !== 1'b0) $display("FAIL midrst_rs1_9 stall got %0b want 0", iss_stall); else passed++;
        iss_valid = 0;
        a_valid = 1; a_rd = 5'd0; b_valid = 1; b_rd = 5'd0;
        #1;
        total++; if (a_ready !== 1'b1) $display("FAIL midrst_tie_a_ready got %0b want 1", a_ready); else passed++;
        total++; if (b_ready !== 1'b0) $display("FAIL midrst_tie_b_ready got %0b want 0", b_ready); else passed++;
        idle_inputs();
        tick();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_raw();
        test_round_robin();
        test_x0_writeback();
        test_waw_same_cycle();
        test_unexpected();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
